// File: rtl/pa_fmau_frac_norm.sv
// pa_fmau_frac_norm: post-adder normalizer for the single-precision FMAU.
// Takes the EX2 adder sum/exponent/sign, normalizes to hidden-one form in
// EX3 (leading-zero count + shift) and registers the result in EX4.
//
// Build option: define FMAU_NORM_SUBNORM_EN to produce subnormal results
// (left shift limited by the exponent) instead of flushing underflow to zero.
//
// Ports:
//   forever_cpuclk, cpurst_b            clock, async active-low reset
//   ctrl_dp_ex2_inst_pipe_down          capture EX2 data into EX3
//   ctrl_dp_ex3_inst_pipe_down          advance EX3 into EX4
//   ctrl_xx_ex3_stall                   hold EX3/EX4
//   ctrl_xx_flush                       kill in-flight entries
//   ex2_adder_sum/_mac_expnt/_sum_sign  EX2 sum magnitude, exponent, sign
//   ex4_norm_*                          registered normalized result
module pa_fmau_frac_norm #(
  parameter int unsigned SUM_W  = 54,
  parameter int unsigned EXP_W  = 10,
  parameter int unsigned FRAC_W = 24
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              ctrl_dp_ex2_inst_pipe_down,
  input  logic              ctrl_dp_ex3_inst_pipe_down,
  input  logic              ctrl_xx_ex3_stall,
  input  logic              ctrl_xx_flush,
  input  logic [SUM_W-1:0]  ex2_adder_sum,
  input  logic [EXP_W-1:0]  ex2_mac_expnt,
  input  logic              ex2_sum_sign,
  output logic              ex4_norm_vld,
  output logic [FRAC_W-1:0] ex4_norm_frac,
  output logic              ex4_norm_guard,
  output logic              ex4_norm_sticky,
  output logic [EXP_W-1:0]  ex4_norm_expnt,
  output logic              ex4_norm_sign,
  output logic              ex4_norm_zero,
  output logic              ex4_norm_uf
);

  // Sum bits below the two carry bits; bit LSH_W-1 is the hidden-one slot.
  localparam int unsigned LSH_W  = SUM_W - 2;
  localparam int unsigned LZ_W   = 6;
  localparam int unsigned GRD_IX = LSH_W - FRAC_W - 1;

  logic              ex3_vld;
  logic [SUM_W-1:0]  ex3_sum;
  logic [EXP_W-1:0]  ex3_expnt;
  logic              ex3_sign;

  logic [LZ_W-1:0]   lz_c;
  logic [LZ_W-1:0]   lsh_c;
  logic [LSH_W-1:0]  lsh_data_c;
  logic [EXP_W-1:0]  res_e_c;
  logic              res_uf_c;
  logic [FRAC_W-1:0] n_frac_c;
  logic              n_guard_c;
  logic              n_sticky_c;
  logic [EXP_W-1:0]  n_expnt_c;
  logic              n_zero_c;
  logic              n_uf_c;
`ifdef FMAU_NORM_SUBNORM_EN
  logic [EXP_W-1:0]  em1_c;
`endif

  // EX3 capture register
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ex3_vld   <= 1'b0;
      ex3_sum   <= '0;
      ex3_expnt <= '0;
      ex3_sign  <= 1'b0;
    end else if (ctrl_xx_flush) begin
      ex3_vld <= 1'b0;
    end else if (!ctrl_xx_ex3_stall) begin
      if (ctrl_dp_ex2_inst_pipe_down) begin
        ex3_vld   <= 1'b1;
        ex3_sum   <= ex2_adder_sum;
        ex3_expnt <= ex2_mac_expnt;
        ex3_sign  <= ex2_sum_sign;
      end else if (ctrl_dp_ex3_inst_pipe_down) begin
        ex3_vld <= 1'b0;
      end
    end
  end

  // Leading-zero count of sum[LSH_W-1:0]; the highest set bit wins
  always_comb begin
    lz_c = '0;
    for (int i = 0; i < LSH_W; i++) begin
      if (ex3_sum[i]) lz_c = LZ_W'(LSH_W - 1 - i);
    end
  end

  // EX3 normalization: right shift for carry-outs, else left shift by lz
  always_comb begin
    lsh_c      = '0;
    lsh_data_c = '0;
    res_e_c    = ex3_expnt;
    n_frac_c   = '0;
    n_guard_c  = 1'b0;
    n_sticky_c = 1'b0;
    n_expnt_c  = '0;
    n_zero_c   = 1'b0;
    n_uf_c     = 1'b0;
`ifdef FMAU_NORM_SUBNORM_EN
    em1_c      = ex3_expnt - EXP_W'(1);
`endif

    if (ex3_sum[SUM_W-1]) begin
      res_e_c    = ex3_expnt + EXP_W'(2);
      n_frac_c   = ex3_sum[SUM_W-1 -: FRAC_W];
      n_guard_c  = ex3_sum[SUM_W-1-FRAC_W];
      n_sticky_c = |ex3_sum[SUM_W-2-FRAC_W:0];
    end else if (ex3_sum[SUM_W-2]) begin
      res_e_c    = ex3_expnt + EXP_W'(1);
      n_frac_c   = ex3_sum[SUM_W-2 -: FRAC_W];
      n_guard_c  = ex3_sum[SUM_W-2-FRAC_W];
      n_sticky_c = |ex3_sum[SUM_W-3-FRAC_W:0];
    end else begin
      // lz is 0 when the hidden one is already in place
      res_e_c = ex3_expnt - EXP_W'(lz_c);
      lsh_c   = lz_c;
`ifdef FMAU_NORM_SUBNORM_EN
      // Stop shifting at exponent 1; under underflow em1 < lz <= 51
      if ($signed(res_e_c) < $signed(EXP_W'(1))) begin
        lsh_c = ($signed(em1_c) <= $signed(EXP_W'(0))) ? '0 : em1_c[LZ_W-1:0];
      end
`endif
      lsh_data_c = ex3_sum[LSH_W-1:0] << lsh_c;
      n_frac_c   = lsh_data_c[LSH_W-1 -: FRAC_W];
      n_guard_c  = lsh_data_c[GRD_IX];
      n_sticky_c = |lsh_data_c[GRD_IX-1:0];
    end

    res_uf_c = $signed(res_e_c) < $signed(EXP_W'(1));

    if (ex3_sum == '0) begin
      n_frac_c   = '0;
      n_guard_c  = 1'b0;
      n_sticky_c = 1'b0;
      n_zero_c   = 1'b1;
    end else if (res_uf_c) begin
      n_uf_c = 1'b1;
`ifndef FMAU_NORM_SUBNORM_EN
      n_frac_c   = '0;
      n_guard_c  = 1'b0;
      n_sticky_c = 1'b0;
      n_zero_c   = 1'b1;
`endif
    end else begin
      n_expnt_c = res_e_c;
    end
  end

  // EX4 result register; valid lasts one unstalled cycle per result
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ex4_norm_vld    <= 1'b0;
      ex4_norm_frac   <= '0;
      ex4_norm_guard  <= 1'b0;
      ex4_norm_sticky <= 1'b0;
      ex4_norm_expnt  <= '0;
      ex4_norm_sign   <= 1'b0;
      ex4_norm_zero   <= 1'b0;
      ex4_norm_uf     <= 1'b0;
    end else if (ctrl_xx_flush) begin
      ex4_norm_vld <= 1'b0;
    end else if (!ctrl_xx_ex3_stall) begin
      if (ctrl_dp_ex3_inst_pipe_down && ex3_vld) begin
        ex4_norm_vld    <= 1'b1;
        ex4_norm_frac   <= n_frac_c;
        ex4_norm_guard  <= n_guard_c;
        ex4_norm_sticky <= n_sticky_c;
        ex4_norm_expnt  <= n_expnt_c;
        ex4_norm_sign   <= ex3_sign;
        ex4_norm_zero   <= n_zero_c;
        ex4_norm_uf     <= n_uf_c;
      end else begin
        ex4_norm_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pa_fmau_frac_norm.sv
// Bench for pa_fmau_frac_norm: table vectors, random vectors with stalls,
// stall/flush/reset sequences; results checked through an in-order scoreboard.
module tb_pa_fmau_frac_norm;

  typedef struct {
    logic [53:0] sum;
    logic [9:0]  expnt;
    logic        sign;
    logic [23:0] frac;
    logic        guard;
    logic        sticky;
    logic [9:0]  r_expnt;
    logic        zero;
    logic        uf;
  } vec_t;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b;
  logic        ctrl_dp_ex2_inst_pipe_down;
  logic        ctrl_dp_ex3_inst_pipe_down;
  logic        ctrl_xx_ex3_stall;
  logic        ctrl_xx_flush;
  logic [53:0] ex2_adder_sum;
  logic [9:0]  ex2_mac_expnt;
  logic        ex2_sum_sign;
  logic        ex4_norm_vld;
  logic [23:0] ex4_norm_frac;
  logic        ex4_norm_guard;
  logic        ex4_norm_sticky;
  logic [9:0]  ex4_norm_expnt;
  logic        ex4_norm_sign;
  logic        ex4_norm_zero;
  logic        ex4_norm_uf;

  pa_fmau_frac_norm dut (
    .forever_cpuclk             (forever_cpuclk),
    .cpurst_b                   (cpurst_b),
    .ctrl_dp_ex2_inst_pipe_down (ctrl_dp_ex2_inst_pipe_down),
    .ctrl_dp_ex3_inst_pipe_down (ctrl_dp_ex3_inst_pipe_down),
    .ctrl_xx_ex3_stall          (ctrl_xx_ex3_stall),
    .ctrl_xx_flush              (ctrl_xx_flush),
    .ex2_adder_sum              (ex2_adder_sum),
    .ex2_mac_expnt              (ex2_mac_expnt),
    .ex2_sum_sign               (ex2_sum_sign),
    .ex4_norm_vld               (ex4_norm_vld),
    .ex4_norm_frac              (ex4_norm_frac),
    .ex4_norm_guard             (ex4_norm_guard),
    .ex4_norm_sticky            (ex4_norm_sticky),
    .ex4_norm_expnt             (ex4_norm_expnt),
    .ex4_norm_sign              (ex4_norm_sign),
    .ex4_norm_zero              (ex4_norm_zero),
    .ex4_norm_uf                (ex4_norm_uf)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  vec_t sb[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   n_issued = 0;

  function automatic vec_t mk(input logic [53:0] s, input logic [9:0] e, input logic sg,
                              input logic [23:0] f, input logic g, input logic st,
                              input logic [9:0] re, input logic z, input logic u);
    vec_t v;
    v.sum = s; v.expnt = e; v.sign = sg; v.frac = f; v.guard = g; v.sticky = st;
    v.r_expnt = re; v.zero = z; v.uf = u;
    return v;
  endfunction

  // Reference: shift a wide window one bit at a time until bit 51 holds the one
  function automatic vec_t model(input logic [53:0] s, input logic [9:0] e_in, input logic sg);
    vec_t v;
    logic [127:0] x;
    int e;
    logic nrm;
    v = mk(s, e_in, sg, 24'h0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b0);
    if (s == 54'h0) begin
      v.zero = 1'b1;
      return v;
    end
    x = {10'h0, s, 64'h0};
    e = $signed(e_in);
    while (x[117:116] != 2'b00) begin
      x = x >> 1;
      e = e + 1;
    end
`ifdef FMAU_NORM_SUBNORM_EN
    while (!x[115] && e > 1) begin
`else
    while (!x[115]) begin
`endif
      x = x << 1;
      e = e - 1;
    end
    nrm = x[115];
    v.frac = x[115:92];
    v.guard = x[91];
    v.sticky = |x[90:0];
    v.r_expnt = 10'(e);
    if (!nrm || e < 1) begin
      v.uf = 1'b1;
      v.r_expnt = 10'h0;
`ifndef FMAU_NORM_SUBNORM_EN
      v.frac = 24'h0;
      v.guard = 1'b0;
      v.sticky = 1'b0;
      v.zero = 1'b1;
`endif
    end
    return v;
  endfunction

  task automatic step(input logic p2, input logic st, input logic fl, input vec_t v);
    ctrl_dp_ex2_inst_pipe_down = p2;
    ctrl_dp_ex3_inst_pipe_down = 1'b1;
    ctrl_xx_ex3_stall = st;
    ctrl_xx_flush = fl;
    ex2_adder_sum = v.sum;
    ex2_mac_expnt = v.expnt;
    ex2_sum_sign = v.sign;
    @(posedge forever_cpuclk);
    if (p2 && !st && !fl) begin
      sb.push_back(v);
      n_issued++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    vec_t nil;
    nil = mk(54'h0, 10'h0, 1'b0, 24'h0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, nil);
  endtask

  // Output monitor: compare every valid cycle, retire only when not stalled
  always @(negedge forever_cpuclk) begin
    if (cpurst_b === 1'b1 && ex4_norm_vld === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_vld: got valid frac=%h expnt=%h, required no valid", ex4_norm_frac, ex4_norm_expnt);
      end else begin
        if ({ex4_norm_frac, ex4_norm_guard, ex4_norm_sticky, ex4_norm_expnt, ex4_norm_sign, ex4_norm_zero, ex4_norm_uf}
            !== {sb[0].frac, sb[0].guard, sb[0].sticky, sb[0].r_expnt, sb[0].sign, sb[0].zero, sb[0].uf}) begin
          n_fail++;
          $display("FAIL result sum=%h e=%h: got f=%h g=%b s=%b e=%h sg=%b z=%b uf=%b, required f=%h g=%b s=%b e=%h sg=%b z=%b uf=%b",
                   sb[0].sum, sb[0].expnt, ex4_norm_frac, ex4_norm_guard, ex4_norm_sticky, ex4_norm_expnt,
                   ex4_norm_sign, ex4_norm_zero, ex4_norm_uf, sb[0].frac, sb[0].guard, sb[0].sticky,
                   sb[0].r_expnt, sb[0].sign, sb[0].zero, sb[0].uf);
        end
        if (ctrl_xx_ex3_stall === 1'b0) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required end before timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_zero_outputs(input string name);
    n_chk++;
    if ({ex4_norm_vld, ex4_norm_frac, ex4_norm_guard, ex4_norm_sticky, ex4_norm_expnt,
         ex4_norm_sign, ex4_norm_zero, ex4_norm_uf} !== 40'h0) begin
      n_fail++;
      $display("FAIL %s: got vld=%b f=%h e=%h z=%b uf=%b, required all zero", name,
               ex4_norm_vld, ex4_norm_frac, ex4_norm_expnt, ex4_norm_zero, ex4_norm_uf);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  vec_t tbl[12];
  vec_t v;
  logic [53:0] one = 54'h1;
  logic [63:0] r;
  int   p;
  int   base;
  logic st;

  initial begin
    tbl[0]  = mk(54'h20_0000_0000_0003, 10'h010, 1'b0, 24'h800000, 1'b0, 1'b1, 10'h012, 1'b0, 1'b0);
    tbl[1]  = mk(one << 40,            10'h020, 1'b1, 24'h800000, 1'b0, 1'b0, 10'h015, 1'b0, 1'b0);
`ifdef FMAU_NORM_SUBNORM_EN
    tbl[2]  = mk(one << 30,            10'h005, 1'b0, 24'h000040, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1);
    tbl[10] = mk(one << 50,            10'h001, 1'b0, 24'h400000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1);
    tbl[11] = mk(one << 53,            10'h3FE, 1'b1, 24'h800000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1);
`else
    tbl[2]  = mk(one << 30,            10'h005, 1'b0, 24'h000000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
    tbl[10] = mk(one << 50,            10'h001, 1'b0, 24'h000000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
    tbl[11] = mk(one << 53,            10'h3FE, 1'b1, 24'h000000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
`endif
    tbl[3]  = mk(54'h0,                10'h07F, 1'b1, 24'h000000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    tbl[4]  = mk((one << 52) | one,    10'h030, 1'b0, 24'h800000, 1'b0, 1'b1, 10'h031, 1'b0, 1'b0);
    tbl[5]  = mk((one << 51) | (one << 27) | one, 10'h040, 1'b1, 24'h800000, 1'b1, 1'b1, 10'h040, 1'b0, 1'b0);
    tbl[6]  = mk((one << 51) | (54'hABCDE << 28), 10'h100, 1'b0, 24'h8ABCDE, 1'b0, 1'b0, 10'h100, 1'b0, 1'b0);
    tbl[7]  = mk(one,                  10'h040, 1'b0, 24'h800000, 1'b0, 1'b0, 10'h00D, 1'b0, 1'b0);
    tbl[8]  = mk((54'h3 << 52) | 54'h2, 10'h001, 1'b1, 24'hC00000, 1'b0, 1'b1, 10'h003, 1'b0, 1'b0);
    tbl[9]  = mk(one << 50,            10'h002, 1'b0, 24'h800000, 1'b0, 1'b0, 10'h001, 1'b0, 1'b0);

    // Reset state
    cpurst_b = 1'b0;
    idle(3);
    check_zero_outputs("reset_state");
    cpurst_b = 1'b1;
    idle(2);

    // Table vectors, back to back
    foreach (tbl[i]) step(1'b1, 1'b0, 1'b0, tbl[i]);
    idle(4);

    // Random vectors with random stalls (a stalled issue is retried)
    for (int k = 0; k < 40; k++) begin
      p = $urandom_range(53, 0);
      r = {$urandom, $urandom};
      v.sum = (54'(r) & ((one << p) - one)) | (one << p);
      if ($urandom_range(3, 0) == 0) v.expnt = 10'($urandom_range(30, 0));
      else v.expnt = 10'($urandom_range(400, 60));
      v.sign = 1'($urandom_range(1, 0));
      v = model(v.sum, v.expnt, v.sign);
      do begin
        st = ($urandom_range(4, 0) == 0);
        step(1'b1, st, 1'b0, v);
      end while (st);
    end
    idle(4);

    // Three back-to-back issues with a stall while the first sits in EX4
    base = n_out;
    step(1'b1, 1'b0, 1'b0, tbl[0]);
    step(1'b1, 1'b0, 1'b0, tbl[1]);
    step(1'b1, 1'b1, 1'b0, tbl[6]);
    step(1'b1, 1'b0, 1'b0, tbl[6]);
    idle(4);
    check_int("stall_seq_count", n_out - base, 3);

    // Flush the cycle after capture: the entry must never appear
    base = n_out;
    step(1'b1, 1'b0, 1'b0, tbl[4]);
    step(1'b0, 1'b0, 1'b1, tbl[4]);
    sb.delete();
    idle(4);
    check_int("flush_no_vld", n_out - base, 0);
    step(1'b1, 1'b0, 1'b0, tbl[7]);
    idle(4);
    check_int("after_flush_count", n_out - base, 1);

    // Reset with entries in EX3 and EX4
    step(1'b1, 1'b0, 1'b0, tbl[5]);
    step(1'b1, 1'b0, 1'b0, tbl[8]);
    cpurst_b = 1'b0;
    #1;
    check_zero_outputs("reset_midflight");
    sb.delete();
    idle(2);
    cpurst_b = 1'b1;
    base = n_out;
    idle(5);
    check_int("post_reset_no_vld", n_out - base, 0);

    check_int("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pa_fmau_frac_norm.md
Name: pa_fmau_frac_norm

Overview:
- Post-adder normalizer for the single-precision FMAU datapath.
- It is the counterpart of the EX2 addend aligner: the aligner right/left-shifts src2 against the product; this block takes the 54-bit adder sum and exponent produced in EX2 and shifts them back to hidden-one form.
- Two pipeline stages. EX3 does leading-zero count and shift; EX4 registers the result for the rounder.

Parameters:
- SUM_W, 54, adder sum width (carry bits 53:52, hidden-one position bit 51)
- EXP_W, 10, signed exponent width (SINGLE_EXPN+2)
- FRAC_W, 24, normalized mantissa width including hidden one

Ports:
- forever_cpuclk  input  1  clock
- cpurst_b  input  1  asynchronous active-low reset
- ctrl_dp_ex2_inst_pipe_down  input  1  capture EX2 data into EX3
- ctrl_dp_ex3_inst_pipe_down  input  1  advance EX3 into EX4
- ctrl_xx_ex3_stall  input  1  hold EX3/EX4 contents
- ctrl_xx_flush  input  1  kill all in-flight entries
- ex2_adder_sum  input  54  unsigned magnitude of adder result
- ex2_mac_expnt  input  10  two's-complement exponent of sum bit 51
- ex2_sum_sign  input  1  result sign
- ex4_norm_vld  output  1  EX4 result valid
- ex4_norm_frac  output  24  normalized mantissa, bit 23 = hidden one
- ex4_norm_guard  output  1  first bit below mantissa
- ex4_norm_sticky  output  1  OR of all lower or shifted-out bits
- ex4_norm_expnt  output  10  adjusted exponent
- ex4_norm_sign  output  1  sign
- ex4_norm_zero  output  1  exact-zero result
- ex4_norm_uf  output  1  underflow (flushed or subnormal)

Behaviour:
- Reset: all EX3/EX4 registers clear. All outputs are 0, including ex4_norm_vld.
- EX3 capture:
  - If pipe_down2 && !stall, EX3 loads sum, expnt and sign, and ex3_vld=1.
  - Else if pipe_down3 && !stall, ex3_vld=0.
  - Else EX3 holds.
- EX4 capture:
  - If pipe_down3 && ex3_vld && !stall, EX4 loads the EX3 normalization result and ex4_vld=1.
  - Else if !stall, ex4_vld=0 (single-cycle valid per result).
- Stall has priority over both pipe_down inputs. Flush has priority over everything: it clears ex3_vld and ex4_vld next cycle, and data registers may keep stale values.
- Latency: an EX2 pipe_down at cycle N gives ex4_norm_vld at N+2 when there is no stall.
- Normalization (EX3, combinational). Let E = ex3 expnt.
  - sum[53]=1: right shift 2, E+2. sticky includes sum[1:0].
  - sum[53:52]=01: right shift 1, E+1. sticky includes sum[0].
  - sum[53:51]=001: no shift.
  - else: lz = leading zeros of sum[51:0] (0..51); left shift lz, E-lz.
  - frac = shifted[51:28], guard = shifted[27], sticky = |shifted[26:0] OR'd with right-shifted-out bits.
- Zero: sum==0 → zero=1, frac/guard/sticky/expnt=0, uf=0, sign passed through.
- Underflow check uses signed 10-bit arithmetic on E-lz. Result < 1 → handling per the optional feature below.
- Exponent arithmetic wraps modulo 2^10. Inputs above +511-2 are not produced upstream; behaviour for them is undefined.

Optional Feature:
- Macro: FMAU_NORM_SUBNORM_EN
- Defined: left shift is limited to max(E-1, 0). Output expnt=0 and uf=1; frac holds the subnormal mantissa (bit 23 may be 0); guard/sticky come from the limited shift.
- Undefined: flush to zero. frac/guard/sticky=0, expnt=0, zero=1, uf=1.

Test Plan:
- Reset mid-flight: entries in EX3 and EX4, assert cpurst_b=0 → all outputs 0 immediately; no valid after release.
- sum=0x20_0000_0000_0003 (bit 53 set, low bits 11), expnt=0x010 → after 2 cycles: frac=0x800000, expnt=0x012, sticky=1, guard=0.
- sum=1<<40, expnt=0x020 → lz=11: frac=0x800000, expnt=0x015, guard=0, sticky=0.
- sum=1<<30, expnt=0x005:
  - without macro → zero=1, uf=1, expnt=0.
  - with macro → shift 4, frac=0x000040 region per limited shift, expnt=0, uf=1.
- Back-to-back pipe_down2 for 3 cycles with a stall on cycle 2 → three valids out, stalled result held, order preserved, no duplicates.
- Flush the cycle after capture → no ex4_norm_vld; the next instruction normalizes correctly.
